obsidian_hazard_controller: RTL and testbench

//  Pipeline sequencer that sits beside the decode stage. Watches the IF_ID instruction, the
//  ID_EX load/destination fields, the WB_ID write port and the EX branch outcome.

---
 rtl/obsidian_hazard_controller_if.sv | 32 +++
 rtl/obsidian_hazard_controller.sv | 138 +++++++++++++
 tb/tb_obsidian_hazard_controller.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/obsidian_hazard_controller_if.sv
// Decode-side hazard controller bundle: pipeline-field observations in, stall/flush controls
// and statistics out.
interface obsidian_hazard_controller_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      if_id_instr;
  logic             id_ex_memread;
  logic [4:0]       id_ex_rd;
  logic             wb_regwrite;
  logic [4:0]       wb_rd;
  logic             ex_branch_taken;
  logic             cnt_clear;
  logic             pc_write_en;
  logic             if_id_write_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output if_id_instr, id_ex_memread, id_ex_rd, wb_regwrite, wb_rd, ex_branch_taken, cnt_clear,
    input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ctrl_state,
           stall_count, flush_count
  );

  modport slave (
    input  if_id_instr, id_ex_memread, id_ex_rd, wb_regwrite, wb_rd, ex_branch_taken, cnt_clear,
    output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ctrl_state,
           stall_count, flush_count
  );
endinterface

// File: rtl/obsidian_hazard_controller.sv
// Pipeline sequencer beside decode: load-use / WB-collision stalls, taken-branch flushes,
// and saturating stall/flush statistics.
module obsidian_hazard_controller #(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input logic clk,
  input logic rst_n,
  obsidian_hazard_controller_if.slave bus
);
  localparam int unsigned MAXC = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
  localparam int unsigned CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] STALL_RELOAD = CW'((STALL_CYCLES > 1) ? STALL_CYCLES - 2 : 0);
  localparam logic [CW-1:0] FLUSH_RELOAD = CW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             rst_hold;
  logic             inc_stall, inc_flush;
  logic [CNT_W-1:0] stall_count, flush_count;

  logic [10:0] opcode;
  logic [4:0]  src1, src2;
  logic        is_store, is_load, load_use, wb_raw, hazard;
  logic        unused_instr_bits;

  assign opcode   = bus.if_id_instr[31:21];
  assign src1     = bus.if_id_instr[9:5];
  assign is_store = (opcode == 11'h7C0) || (opcode == 11'h5E0) || (opcode == 11'h7E0);
  assign is_load  = (opcode == 11'h7C2) || (opcode == 11'h5E2) || (opcode == 11'h7E2);
  // Loads have no second source; park src2 on XZR so it can never match.
  assign src2     = is_load  ? 5'd31 :
                    is_store ? bus.if_id_instr[4:0] : bus.if_id_instr[20:16];
  assign unused_instr_bits = ^bus.if_id_instr[15:10];

  assign load_use = bus.id_ex_memread && (bus.id_ex_rd != 5'd31) &&
                    ((bus.id_ex_rd == src1) || (bus.id_ex_rd == src2));
  assign wb_raw   = bus.wb_regwrite && (bus.wb_rd != 5'd31) &&
                    ((bus.wb_rd == src1) || (bus.wb_rd == src2));
  assign hazard   = load_use || wb_raw;

  // Held high from reset assertion until the first clock edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_hold <= 1'b1;
    else        rst_hold <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    inc_stall          = 1'b0;
    inc_flush          = 1'b0;
    bus.pc_write_en    = 1'b1;
    bus.if_id_write_en = 1'b1;
    bus.if_id_flush    = 1'b0;
    bus.id_ex_bubble   = 1'b0;
    if (rst_hold) begin
      bus.pc_write_en    = 1'b0;
      bus.if_id_write_en = 1'b0;
      bus.if_id_flush    = 1'b1;
      bus.id_ex_bubble   = 1'b1;
      state_nxt          = RUN;
      cnt_nxt            = '0;
    end else if (bus.ex_branch_taken) begin
      bus.if_id_flush  = 1'b1;
      bus.id_ex_bubble = 1'b1;
      inc_flush        = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nxt = FLUSH;
        cnt_nxt   = FLUSH_RELOAD;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      unique case (state)
        RUN: if (hazard) begin
          bus.pc_write_en    = 1'b0;
          bus.if_id_write_en = 1'b0;
          bus.id_ex_bubble   = 1'b1;
          inc_stall          = 1'b1;
          if (STALL_CYCLES > 1) begin
            state_nxt = STALL;
            cnt_nxt   = STALL_RELOAD;
          end
        end
        STALL: begin
          bus.pc_write_en    = 1'b0;
          bus.if_id_write_en = 1'b0;
          bus.id_ex_bubble   = 1'b1;
          inc_stall          = 1'b1;
          if (cnt == '0) state_nxt = RUN;
          else           cnt_nxt   = cnt - 1'b1;
        end
        FLUSH: begin
          bus.if_id_flush  = 1'b1;
          bus.id_ex_bubble = 1'b1;
          if (cnt == '0) state_nxt = RUN;
          else           cnt_nxt   = cnt - 1'b1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (bus.cnt_clear) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (inc_stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (inc_flush && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

  assign bus.ctrl_state  = state;
  assign bus.stall_count = stall_count;
  assign bus.flush_count = flush_count;
endmodule

// File: tb/tb_obsidian_hazard_controller.sv
// Directed bench: default-parameter instance A plus a STALL_CYCLES=3 / CNT_W=4 instance B.
module tb_obsidian_hazard_controller;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] ADD_X5_X3_X4  = 32'h8B040065;
  localparam logic [31:0] ADD_X5_XZR_X4 = 32'h8B0403E5;
  localparam logic [31:0] STUR_X31_X2   = 32'hF800005F;
  localparam logic [31:0] STUR_X7_X2    = 32'hF8000047;
  localparam logic [31:0] STUR_X6_IMM7  = 32'hF8070046;
  localparam logic [31:0] LDUR_X1_IMM7  = 32'hF8470041;
  localparam logic [31:0] LDUR_X1_X7    = 32'hF84000E1;

  obsidian_hazard_controller_if #(.CNT_W(16)) ia ();
  obsidian_hazard_controller_if #(.CNT_W(4))  ib ();

  obsidian_hazard_controller #(.STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave)
  );
  obsidian_hazard_controller #(.STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control outputs packed as {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble}
  task automatic outs_a(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, ia.pc_write_en, ia.if_id_write_en, ia.if_id_flush, ia.id_ex_bubble}, {28'd0, exp});
  endtask
  task automatic outs_b(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, ib.pc_write_en, ib.if_id_write_en, ib.if_id_flush, ib.id_ex_bubble}, {28'd0, exp});
  endtask

  task automatic idle_a();
    ia.if_id_instr = 32'd0; ia.id_ex_memread = 1'b0; ia.id_ex_rd = 5'd0;
    ia.wb_regwrite = 1'b0;  ia.wb_rd = 5'd0; ia.ex_branch_taken = 1'b0; ia.cnt_clear = 1'b0;
  endtask
  task automatic idle_b();
    ib.if_id_instr = 32'd0; ib.id_ex_memread = 1'b0; ib.id_ex_rd = 5'd0;
    ib.wb_regwrite = 1'b0;  ib.wb_rd = 5'd0; ib.ex_branch_taken = 1'b0; ib.cnt_clear = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_a();
    idle_b();
    #12;
    outs_a("rst_outs_a", 4'b0011);
    chk("rst_state_a", {30'd0, ia.ctrl_state}, 32'd0);
    chk("rst_stall_a", {16'd0, ia.stall_count}, 32'd0);
    chk("rst_flush_a", {16'd0, ia.flush_count}, 32'd0);
    #8 rst_n = 1'b1;
    #1 outs_a("rel_hold_a", 4'b0011);
    tick();
    outs_a("run_idle_a", 4'b1100);
    outs_b("run_idle_b", 4'b1100);

    // Load-use on Rn
    ia.id_ex_memread = 1'b1; ia.id_ex_rd = 5'd3; ia.if_id_instr = ADD_X5_X3_X4;
    #1 outs_a("lu_outs", 4'b0001);
    tick();
    chk("lu_stall_cnt", {16'd0, ia.stall_count}, 32'd1);
    chk("lu_state", {30'd0, ia.ctrl_state}, 32'd0);
    idle_a();
    #1 outs_a("lu_release", 4'b1100);

    // XZR never matches
    ia.id_ex_memread = 1'b1; ia.id_ex_rd = 5'd31; ia.if_id_instr = ADD_X5_XZR_X4;
    #1 outs_a("xzr_rn", 4'b1100);
    ia.if_id_instr = STUR_X31_X2;
    #1 outs_a("xzr_stur", 4'b1100);

    // Store uses Rt as src2; loads use Rn only
    ia.id_ex_rd = 5'd7; ia.if_id_instr = STUR_X7_X2;
    #1 outs_a("stur_rt", 4'b0001);
    tick();
    chk("stur_stall_cnt", {16'd0, ia.stall_count}, 32'd2);
    ia.if_id_instr = STUR_X6_IMM7;
    #1 outs_a("stur_imm_nomatch", 4'b1100);
    ia.if_id_instr = LDUR_X1_IMM7;
    #1 outs_a("ldur_nosrc2", 4'b1100);
    ia.if_id_instr = LDUR_X1_X7;
    #1 outs_a("ldur_rn", 4'b0001);
    tick();
    chk("ldur_stall_cnt", {16'd0, ia.stall_count}, 32'd3);

    // WB collision on Rm
    idle_a();
    ia.wb_regwrite = 1'b1; ia.wb_rd = 5'd4; ia.if_id_instr = ADD_X5_X3_X4;
    #1 outs_a("wb_hit", 4'b0001);
    tick();
    chk("wb_stall_cnt", {16'd0, ia.stall_count}, 32'd4);
    ia.wb_rd = 5'd6;
    #1 outs_a("wb_miss", 4'b1100);
    ia.wb_rd = 5'd4; ia.wb_regwrite = 1'b0;
    #1 outs_a("wb_nowrite", 4'b1100);

    // Branch beats hazard; hazard ignored during FLUSH
    ia.wb_regwrite = 1'b1; ia.ex_branch_taken = 1'b1;
    #1 outs_a("br_outs", 4'b1111);
    tick();
    chk("br_state", {30'd0, ia.ctrl_state}, 32'd2);
    chk("br_flush_cnt", {16'd0, ia.flush_count}, 32'd1);
    ia.ex_branch_taken = 1'b0;
    #1 outs_a("flush_outs", 4'b1111);
    tick();
    chk("flush_done_state", {30'd0, ia.ctrl_state}, 32'd0);
    chk("flush_stall_cnt", {16'd0, ia.stall_count}, 32'd4);

    // Clear wins over a simultaneous increment
    ia.cnt_clear = 1'b1;
    #1 outs_a("clr_outs", 4'b0001);
    tick();
    chk("clr_stall_a", {16'd0, ia.stall_count}, 32'd0);
    chk("clr_flush_a", {16'd0, ia.flush_count}, 32'd0);
    idle_a();

    // B: branch during a 3-cycle stall
    ib.id_ex_memread = 1'b1; ib.id_ex_rd = 5'd3; ib.if_id_instr = ADD_X5_X3_X4;
    #1 outs_b("bs_c1", 4'b0001);
    tick();
    chk("bs_c1_state", {30'd0, ib.ctrl_state}, 32'd1);
    outs_b("bs_c2", 4'b0001);
    tick();
    chk("bs_c2_stall", {28'd0, ib.stall_count}, 32'd2);
    ib.ex_branch_taken = 1'b1;
    #1 outs_b("bs_c3_flush", 4'b1111);
    tick();
    chk("bs_c3_state", {30'd0, ib.ctrl_state}, 32'd2);
    ib.ex_branch_taken = 1'b0; ib.id_ex_memread = 1'b0;
    #1 outs_b("bs_c4_flush", 4'b1111);
    tick();
    chk("bs_end_state", {30'd0, ib.ctrl_state}, 32'd0);
    chk("bs_stall_cnt", {28'd0, ib.stall_count}, 32'd2);
    chk("bs_flush_cnt", {28'd0, ib.flush_count}, 32'd1);

    // B: saturation at 4 bits, then clear under a live hazard
    ib.id_ex_memread = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", {28'd0, ib.stall_count}, 32'd15);
    ib.cnt_clear = 1'b1;
    tick();
    chk("sat_clear_stall", {28'd0, ib.stall_count}, 32'd0);
    chk("sat_clear_flush", {28'd0, ib.flush_count}, 32'd0);
    ib.cnt_clear = 1'b0;

    // B: reset asserted mid-STALL
    ib.id_ex_memread = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_run", {30'd0, ib.ctrl_state}, 32'd0);
    ib.id_ex_memread = 1'b1;
    tick();
    chk("pre_rst_stall", {30'd0, ib.ctrl_state}, 32'd1);
    #2 rst_n = 1'b0;
    #1 outs_b("mid_rst_outs", 4'b0011);
    chk("mid_rst_state", {30'd0, ib.ctrl_state}, 32'd0);
    chk("mid_rst_stall", {28'd0, ib.stall_count}, 32'd0);
    idle_b();
    #1 rst_n = 1'b1;
    #1 outs_b("mid_rel_hold", 4'b0011);
    tick();
    outs_b("mid_rel_run", 4'b1100);
    chk("mid_rel_state", {30'd0, ib.ctrl_state}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
